// File: rtl/ram_dma_pkg.sv
// Shared constants and FSM encoding for the RAM block-move/fill engine.
package ram_dma_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 32;

  localparam logic OP_COPY = 1'b0;
  localparam logic OP_FILL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_LAT  = 3'd2,
    ST_WR   = 3'd3,
    ST_FILL = 3'd4,
    ST_FIN  = 3'd5
  } state_e;

endpackage

// File: rtl/ram_dma_ptr.sv
// Source/destination pointer pair and written-word counter for ram_copy_dma.
// Pointers wrap modulo the RAM depth; last_o flags the final word of the block.
module ram_dma_ptr
  import ram_dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              advance_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [ADDR_W:0]   len_i,
  output logic [ADDR_W-1:0] src_nxt_o,
  output logic [ADDR_W-1:0] dst_o,
  output logic [ADDR_W-1:0] dst_nxt_o,
  output logic [ADDR_W:0]   cnt_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W-1:0] src_q, dst_q;
  logic [ADDR_W:0]   cnt_q, len_q;

  // Load the block parameters on start, step all three on every written word.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q <= '0;
      dst_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
    end else if (load_i) begin
      src_q <= src_i;
      dst_q <= dst_i;
      cnt_q <= '0;
      len_q <= len_i;
    end else if (advance_i) begin
      src_q <= src_q + PTR_ONE;
      dst_q <= dst_q + PTR_ONE;
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign src_nxt_o = src_q + PTR_ONE;
  assign dst_o     = dst_q;
  assign dst_nxt_o = dst_q + PTR_ONE;
  assign cnt_o     = cnt_q;
  assign last_o    = (cnt_q == len_q - CNT_ONE);

endmodule

// File: rtl/ram_copy_dma.sv
// Block copy / constant fill engine driving a registered-read single-port RAM.
// Copy takes RD -> LAT -> WR per word; fill writes one word per cycle.
// Every RAM-side output is registered, decoded from the next state.
module ram_copy_dma
  import ram_dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W:0]   words_done,
  output logic [ADDR_W-1:0] address,
  output logic              enable_read,
  output logic              enable_write,
  output logic [DATA_W-1:0] DMin,
  input  logic [DATA_W-1:0] DMout
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic              load, advance, abort_take;
  logic [ADDR_W:0]   len_sat;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] dmin_d;

  logic [ADDR_W-1:0] src_nxt, dst_ptr, dst_nxt;
  logic              last_word;

  logic              busy_q, done_q, aborted_q, en_rd_q, en_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dmin_q;

  assign len_sat = (length > DEPTH) ? DEPTH : length;
  assign advance = (state_q == ST_WR) || (state_q == ST_FILL);
  assign fill_d  = load ? fill_data : fill_q;

  ram_dma_ptr #(.ADDR_W(ADDR_W)) u_ptr (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .advance_i (advance),
    .src_i     (src_addr),
    .dst_i     (dst_addr),
    .len_i     (len_sat),
    .src_nxt_o (src_nxt),
    .dst_o     (dst_ptr),
    .dst_nxt_o (dst_nxt),
    .cnt_o     (words_done),
    .last_o    (last_word)
  );

  // Next-state logic; abort overrides any active state, a finished op ignores it.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    abort_take = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          load = 1'b1;
          if (len_sat == '0)       state_d = ST_FIN;
          else if (op == OP_FILL)  state_d = ST_FILL;
          else                     state_d = ST_RD;
        end
      end
      ST_RD:   state_d = ST_LAT;
      ST_LAT:  state_d = ST_WR;
      ST_WR:   state_d = last_word ? ST_FIN : ST_RD;
      ST_FILL: state_d = last_word ? ST_FIN : ST_FILL;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE) && (state_q != ST_FIN)) begin
      state_d    = ST_IDLE;
      abort_take = 1'b1;
    end
  end

  // RAM address and write data for the cycle the FSM is about to enter.
  always_comb begin
    addr_d = '0;
    dmin_d = '0;
    case (state_d)
      ST_RD:   addr_d = (state_q == ST_IDLE) ? src_addr : src_nxt;
      ST_WR: begin
        addr_d = dst_ptr;
        dmin_d = DMout;
      end
      ST_FILL: begin
        addr_d = (state_q == ST_IDLE) ? dst_addr : dst_nxt;
        dmin_d = fill_d;
      end
      default: ;
    endcase
  end

  // State, latched fill word and registered RAM/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      fill_q    <= '0;
      addr_q    <= '0;
      dmin_q    <= '0;
      en_rd_q   <= 1'b0;
      en_wr_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      addr_q    <= addr_d;
      dmin_q    <= dmin_d;
      en_rd_q   <= (state_d == ST_RD);
      en_wr_q   <= (state_d == ST_WR) || (state_d == ST_FILL);
      busy_q    <= state_d inside {ST_RD, ST_LAT, ST_WR, ST_FILL};
      done_q    <= (state_d == ST_FIN);
      aborted_q <= abort_take;
    end
  end

  assign address      = addr_q;
  assign DMin         = dmin_q;
  assign enable_read  = en_rd_q;
  assign enable_write = en_wr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = aborted_q;

endmodule

// File: tb/tb_ram_copy_dma.sv
// Directed bench: ram_copy_dma driving a behavioural 64x32 RAM, with a write
// scoreboard fed from a shadow-memory model and cycle-exact pulse checks.
module tb_ram_copy_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, op = 1'b0, abort = 1'b0;
  logic [5:0]  src_addr = '0, dst_addr = '0;
  logic [6:0]  length = '0;
  logic [31:0] fill_data = '0;
  logic        busy, done, aborted, enable_read, enable_write;
  logic [6:0]  words_done;
  logic [5:0]  address;
  logic [31:0] DMin, DMout;

  // RAM model with a backdoor preload port
  logic [31:0] mem [64];
  logic        bd_we = 1'b0;
  logic [5:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (enable_write) mem[address] <= DMin;
    if (enable_read) DMout <= mem[address];
  end

  ram_copy_dma dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_addr(src_addr), .dst_addr(dst_addr),
    .length(length), .fill_data(fill_data), .abort(abort), .busy(busy), .done(done),
    .aborted(aborted), .words_done(words_done), .address(address),
    .enable_read(enable_read), .enable_write(enable_write), .DMin(DMin), .DMout(DMout)
  );

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q [$];
  logic [31:0] shadow [64];
  int          vectors = 0;
  int          miscompares = 0;

  int r_end, r_wr, r_rd;
  bit r_done, r_abort, r_busy1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},  64'(busy), 64'd0);
    check({tag, "_done"},  64'(done), 64'd0);
    check({tag, "_abt"},   64'(aborted), 64'd0);
    check({tag, "_wd"},    64'(words_done), 64'd0);
    check({tag, "_addr"},  64'(address), 64'd0);
    check({tag, "_rd"},    64'(enable_read), 64'd0);
    check({tag, "_wr"},    64'(enable_write), 64'd0);
    check({tag, "_dmin"},  64'(DMin), 64'd0);
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = 6'(a); bd_data = d; shadow[a] = d;
  endtask

  // Forward word-by-word model; only the first n words are expected to land.
  task automatic model_copy(input int s, input int d, input int n);
    for (int i = 0; i < n; i++) begin
      shadow[(d + i) % 64] = shadow[(s + i) % 64];
      exp_q.push_back('{addr: 6'((d + i) % 64), data: shadow[(d + i) % 64]});
    end
  endtask

  task automatic model_fill(input int d, input int n, input logic [31:0] f);
    for (int i = 0; i < n; i++) begin
      shadow[(d + i) % 64] = f;
      exp_q.push_back('{addr: 6'((d + i) % 64), data: f});
    end
  endtask

  task automatic start_op(input logic o, input int s, input int d, input int l, input logic [31:0] f);
    @(negedge clk);
    bd_we = 1'b0;
    op = o; src_addr = 6'(s); dst_addr = 6'(d); length = 7'(l); fill_data = f; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Watch the DUT from cycle 1 until done/aborted, optionally injecting abort,
  // a stray start or an async reset in a chosen cycle.
  task automatic run(input int budget, input int abort_at, input int start_at, input int rst_at);
    bit  fin = 1'b0;
    wr_t w;
    r_end = 0; r_wr = 0; r_rd = 0; r_done = 1'b0; r_abort = 1'b0; r_busy1 = busy;
    for (int c = 1; c <= budget && !fin; c++) begin
      if (c > 1) @(negedge clk);
      abort = (c == abort_at);
      start = (c == start_at);
      if (c == start_at) begin
        op = 1'b1; dst_addr = 6'd0; length = 7'd2;
      end
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        check_outputs_zero("rst_mid");
        fin = 1'b1; r_end = c;
      end else begin
        if (enable_read) r_rd++;
        check("rd_wr_exclusive", 64'(enable_read & enable_write), 64'd0);
        if (enable_write) begin
          r_wr++;
          check("write_pending", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check("write_addr", 64'(address), 64'(w.addr));
            check("write_data", 64'(DMin), 64'(w.data));
          end
        end
        if (done || aborted) begin
          r_done = done; r_abort = aborted; r_end = c; fin = 1'b1;
        end
      end
    end
    abort = 1'b0;
    start = 1'b0;
    check("run_terminated", 64'(fin), 64'd1);
  endtask

  task automatic check_ram(input string tag);
    for (int a = 0; a < 64; a++)
      check($sformatf("%s_ram[%0d]", tag, a), 64'(mem[a]), 64'(shadow[a]));
  endtask

  task automatic expect_end(input string tag, input int end_c, input bit e_done, input bit e_abort,
                            input int wd, input int nwr, input bit busy1);
    check({tag, "_end_cycle"}, 64'(r_end), 64'(end_c));
    check({tag, "_done"},      64'(r_done), 64'(e_done));
    check({tag, "_aborted"},   64'(r_abort), 64'(e_abort));
    check({tag, "_words"},     64'(words_done), 64'(wd));
    check({tag, "_writes"},    64'(r_wr), 64'(nwr));
    check({tag, "_busy1"},     64'(r_busy1), 64'(busy1));
    check({tag, "_busy_end"},  64'(busy), 64'd0);
    check({tag, "_sb_empty"},  64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check({tag, "_done_width"}, 64'(done), 64'd0);
    check({tag, "_abt_width"},  64'(aborted), 64'd0);
    check_ram(tag);
  endtask

  initial begin
    // reset state, background pattern loaded while reset is held
    @(negedge clk);
    check_outputs_zero("reset");
    for (int a = 0; a < 64; a++) poke(a, 32'h5a5a_0000 + 32'(a));
    @(negedge clk);
    bd_we = 1'b0;
    rst = 1'b0;

    // 1: basic copy
    poke(0, 32'h0000_0afc); poke(1, 32'h0000_b031); poke(2, 32'hf000_0005); poke(3, 32'h0000_0246);
    model_copy(0, 8, 4);
    start_op(1'b0, 0, 8, 4, 32'h0);
    run(100, 0, 0, 0);
    check("copy_reads", 64'(r_rd), 64'd4);
    expect_end("copy", 13, 1'b1, 1'b0, 4, 4, 1'b1);

    // 2: fill across the wrap point
    model_fill(40, 64, 32'hffff_ffff);
    start_op(1'b1, 0, 40, 64, 32'hffff_ffff);
    run(100, 0, 0, 0);
    expect_end("fill_wrap", 65, 1'b1, 1'b0, 64, 64, 1'b1);

    // 3: copy with source wrapping 63 -> 0
    poke(62, 32'h0000_046a); poke(63, 32'h03c1_0dd3); poke(0, 32'h0000_00a9); poke(1, 32'h0000_006e);
    model_copy(62, 10, 4);
    start_op(1'b0, 62, 10, 4, 32'h0);
    run(100, 0, 0, 0);
    expect_end("copy_wrap", 13, 1'b1, 1'b0, 4, 4, 1'b1);

    // 4: forward overlap propagates the first word
    poke(0, 32'h0000_0123);
    model_copy(0, 1, 3);
    start_op(1'b0, 0, 1, 3, 32'h0);
    run(100, 0, 0, 0);
    expect_end("overlap", 10, 1'b1, 1'b0, 3, 3, 1'b1);

    // 5a: zero length completes in cycle 1 without RAM access
    start_op(1'b0, 5, 20, 0, 32'h0);
    run(100, 0, 0, 0);
    check("len0_reads", 64'(r_rd), 64'd0);
    expect_end("len0", 1, 1'b1, 1'b0, 0, 0, 1'b0);

    // 5b: oversize length saturates to the RAM depth
    model_fill(5, 64, 32'h1357_9bdf);
    start_op(1'b1, 0, 5, 100, 32'h1357_9bdf);
    run(200, 0, 0, 0);
    expect_end("len_sat", 65, 1'b1, 1'b0, 64, 64, 1'b1);

    // 5c: start pulsed mid-copy is ignored
    model_copy(16, 24, 5);
    start_op(1'b0, 16, 24, 5, 32'h0);
    run(100, 0, 4, 0);
    expect_end("restart_ignored", 16, 1'b1, 1'b0, 5, 5, 1'b1);

    // abort while idle has no effect
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("idle_abort", 64'(aborted), 64'd0);
    check("idle_abort_busy", 64'(busy), 64'd0);

    // 6a: abort during word 2 of 4 leaves dst+2.. untouched
    model_copy(32, 48, 2);
    start_op(1'b0, 32, 48, 4, 32'h0);
    run(100, 7, 0, 0);
    expect_end("abort", 8, 1'b0, 1'b1, 2, 2, 1'b1);

    // 6b: async reset mid-fill, then a fresh copy
    model_fill(0, 9, 32'h0bad_f00d);
    start_op(1'b1, 0, 0, 64, 32'h0bad_f00d);
    run(100, 0, 0, 10);
    @(negedge clk);
    check_outputs_zero("rst_hold");
    rst = 1'b0;
    check("rst_sb_empty", 64'(exp_q.size()), 64'd0);
    check_ram("rst");
    model_copy(0, 60, 3);
    start_op(1'b0, 0, 60, 3, 32'h0);
    run(100, 0, 0, 0);
    expect_end("fresh", 10, 1'b1, 1'b0, 3, 3, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
